// File: rtl/branch_resolver.sv
// branch_resolver: ROB-side tracker for in-flight branches. Latches each
// branch's {predicted, actual} result by ROB index, answers in-order commit
// requests from the ROB head, and raises a one-cycle flush on a mispredict.
// Optional build macro BRANCH_RESOLVER_STATS_EN adds commit/mispredict counters.
module branch_resolver #(
  parameter int ROB_ENTRY_WIDTH = 4,
  parameter int MAX_PENDING     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] alloc_index,
  output logic                       bra_stall,
  input  logic                       bra_in_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] bra_in_index,
  input  logic [1:0]                 bra_in_result,
  input  logic                       commit_req,
  input  logic [ROB_ENTRY_WIDTH-1:0] commit_index,
  output logic                       commit_ack,
  output logic                       commit_taken,
  output logic                       commit_mispredict,
  output logic                       flush,
  output logic [ROB_ENTRY_WIDTH:0]   pending_count
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0]                stat_commits,
  output logic [31:0]                stat_mispredicts
`endif
);

  localparam int NUM_ENTRIES = 2 ** ROB_ENTRY_WIDTH;
  localparam int CNT_W       = ROB_ENTRY_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } entry_state_e;

  entry_state_e state_q [NUM_ENTRIES];
  entry_state_e state_d [NUM_ENTRIES];
  logic         pred_q  [NUM_ENTRIES];
  logic         pred_d  [NUM_ENTRIES];
  logic         act_q   [NUM_ENTRIES];
  logic         act_d   [NUM_ENTRIES];

  logic [CNT_W-1:0] pending_count_q, pending_count_d;
  logic             commit_ack_q, commit_ack_d;
  logic             commit_taken_q, commit_taken_d;
  logic             commit_mispredict_q, commit_mispredict_d;
  logic             flush_q, flush_d;

  logic alloc_fire_s;
  logic resolve_fire_s;
  logic commit_fire_s;
  logic head_act_s;
  logic head_mispredict_s;
  logic flush_fire_s;

  // Stall is combinational on the registered pending count.
  assign bra_stall = (pending_count_q == CNT_W'(MAX_PENDING));

  // Qualify the three request types against the current entry states.
  always_comb begin
    alloc_fire_s      = alloc_valid && !bra_stall && (state_q[alloc_index] == ST_IDLE);
    resolve_fire_s    = bra_in_valid && (state_q[bra_in_index] == ST_WAIT);
    // Blocking on commit_ack_q guarantees a gap cycle between acks.
    commit_fire_s     = commit_req && !commit_ack_q && (state_q[commit_index] == ST_DONE);
    head_act_s        = act_q[commit_index];
    head_mispredict_s = pred_q[commit_index] ^ act_q[commit_index];
    flush_fire_s      = commit_fire_s && head_mispredict_s;
  end

  // Next-state for the entry table and pending count; flush overrides everything.
  // Alloc (IDLE), resolve (WAIT) and commit (DONE) can never target the same entry.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      pred_d[i]  = pred_q[i];
      act_d[i]   = act_q[i];
    end
    pending_count_d = pending_count_q;

    if (flush_fire_s) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_d[i] = ST_IDLE;
        pred_d[i]  = 1'b0;
        act_d[i]   = 1'b0;
      end
      pending_count_d = {CNT_W{1'b0}};
    end else begin
      if (alloc_fire_s) begin
        state_d[alloc_index] = ST_WAIT;
        pending_count_d      = pending_count_d + CNT_W'(1);
      end else begin
        pending_count_d = pending_count_d;
      end

      if (resolve_fire_s) begin
        state_d[bra_in_index] = ST_DONE;
        pred_d[bra_in_index]  = bra_in_result[1];
        act_d[bra_in_index]   = bra_in_result[0];
      end else begin
        state_d[bra_in_index] = state_d[bra_in_index];
      end

      if (commit_fire_s) begin
        state_d[commit_index] = ST_IDLE;
        pending_count_d       = pending_count_d - CNT_W'(1);
      end else begin
        pending_count_d = pending_count_d;
      end
    end
  end

  // Next-state for the registered commit/flush outputs; zero between acks.
  always_comb begin
    if (commit_fire_s) begin
      commit_ack_d        = 1'b1;
      commit_taken_d      = head_act_s;
      commit_mispredict_d = head_mispredict_s;
      flush_d             = head_mispredict_s;
    end else begin
      commit_ack_d        = 1'b0;
      commit_taken_d      = 1'b0;
      commit_mispredict_d = 1'b0;
      flush_d             = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= ST_IDLE;
        pred_q[i]  <= 1'b0;
        act_q[i]   <= 1'b0;
      end
      pending_count_q     <= {CNT_W{1'b0}};
      commit_ack_q        <= 1'b0;
      commit_taken_q      <= 1'b0;
      commit_mispredict_q <= 1'b0;
      flush_q             <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
        pred_q[i]  <= pred_d[i];
        act_q[i]   <= act_d[i];
      end
      pending_count_q     <= pending_count_d;
      commit_ack_q        <= commit_ack_d;
      commit_taken_q      <= commit_taken_d;
      commit_mispredict_q <= commit_mispredict_d;
      flush_q             <= flush_d;
    end
  end

  assign pending_count     = pending_count_q;
  assign commit_ack        = commit_ack_q;
  assign commit_taken      = commit_taken_q;
  assign commit_mispredict = commit_mispredict_q;
  assign flush             = flush_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_commits_q, stat_commits_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Counters advance on the same edge that raises commit_ack / flush; wrap naturally.
  always_comb begin
    if (commit_fire_s) begin
      stat_commits_d = stat_commits_q + 32'd1;
    end else begin
      stat_commits_d = stat_commits_q;
    end
    if (flush_fire_s) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end else begin
      stat_mispredicts_d = stat_mispredicts_q;
    end
  end

  // Statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_commits_q     <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_commits_q     <= stat_commits_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_commits     = stat_commits_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- ROB-side consumer of branch results produced by the branch reservation station/ALU.
- Tracks every in-flight branch by ROB entry index and latches its 2-bit resolution result {predicted, actual}.
- Answers in-order commit requests from the ROB head with taken/mispredict status.
- On a mispredicted commit, raises a one-cycle flush and clears all branch state. Also back-pressures the decoder when too many branches are pending.

Parameters:
- ROB_ENTRY_WIDTH, 4, width of the ROB index; the table holds 2**ROB_ENTRY_WIDTH entries.
- MAX_PENDING, 4, maximum number of non-IDLE entries before stall is asserted; matches the branch queue depth.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  decoder issues a branch into the ROB this cycle.
- alloc_index  in  ROB_ENTRY_WIDTH  ROB entry allocated to that branch.
- bra_stall  out  1  combinational; 1 when pending count == MAX_PENDING.
- bra_in_valid  in  1  branch result valid, from the branch ALU.
- bra_in_index  in  ROB_ENTRY_WIDTH  ROB entry of the resolved branch.
- bra_in_result  in  2  {predicted_taken, actual_taken}.
- commit_req  in  1  ROB head is a branch; held high until acknowledged.
- commit_index  in  ROB_ENTRY_WIDTH  ROB head index.
- commit_ack  out  1  registered one-cycle pulse; the head branch is retired.
- commit_taken  out  1  actual direction; valid with commit_ack.
- commit_mispredict  out  1  predicted != actual; valid with commit_ack.
- flush  out  1  registered one-cycle pulse; equals commit_ack & commit_mispredict.
- pending_count  out  ROB_ENTRY_WIDTH+1  number of non-IDLE entries.

Behaviour:
- Per-entry state is 2-bit: IDLE=0, WAIT=1, DONE=2. Each entry also stores pred and act bits.

Reset:
- All entries go to IDLE with pred = act = 0.
- pending_count = 0.
- commit_ack, commit_taken, commit_mispredict and flush = 0.
- Reset mid-operation discards all pending branches, with no ack or flush.

Allocation:
- At an edge with alloc_valid and bra_stall = 0, entry[alloc_index] goes to WAIT and pending_count increments.
- alloc_valid while bra_stall = 1 is ignored; the decoder must hold the branch.
- Allocation to a non-IDLE entry is ignored.

Resolution:
- At an edge with bra_in_valid, if entry[bra_in_index] is WAIT: store {pred, act} and go to DONE.
- If the entry is IDLE or DONE, the result is ignored. This covers stale results after a flush and duplicates.

Commit:
- At an edge with commit_req, if entry[commit_index] is DONE and commit_ack is currently 0:
  - commit_ack = 1 next cycle;
  - commit_taken = act;
  - commit_mispredict = pred ^ act;
  - the entry goes to IDLE and pending_count decrements.
- If the entry is WAIT or IDLE, no ack is produced; the ROB keeps requesting.
- commit_ack is never high in two consecutive cycles. This gives the ROB one cycle to advance its head.
- Latency: a result latched at edge T can be acked at edge T+1 at the earliest. There is no same-cycle bypass from bra_in to commit.

Flush:
- At the edge that sets commit_mispredict = 1, flush = 1 for exactly one cycle.
- At that same edge, all entries go to IDLE and pending_count goes to 0.
- Any alloc or bra_in sampled at that edge is discarded (flush has priority).

Simultaneous events:
- Alloc and a non-mispredict commit at the same edge leave pending_count unchanged.
- Resolve and alloc to different entries at the same edge are both applied.

Outputs between acks:
- commit_taken and commit_mispredict return to 0 when commit_ack is 0.

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- When defined, adds outputs stat_commits [31:0] and stat_mispredicts [31:0].
  - stat_commits increments on every commit_ack.
  - stat_mispredicts increments on every flush.
  - Both reset to 0 and wrap modulo 2**32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then alloc index 3, resolve index 3 with result 2'b11, commit_req index 3 → commit_ack = 1, commit_taken = 1, mispredict = 0, flush = 0, pending_count 1→0.
- Alloc indices 1, 2, 5, 7 → bra_stall = 1 and pending_count = 4. Alloc index 9 → ignored. Commit index 1 (resolved 2'b00) → stall drops next cycle.
- Alloc 4 and 6, resolve 4 with 2'b10, commit index 4 → commit_ack = flush = mispredict = 1, commit_taken = 0. pending_count = 0 next cycle. A later bra_in for index 6 is ignored and entry 6 stays IDLE.
- commit_req for index 2 held while entry 2 is WAIT for 3 cycles, then resolved 2'b01 → commit_ack exactly one cycle after the resolve edge, commit_mispredict = 1.
- Alloc index 8 at the same edge as the commit of index 3 (correct prediction) → pending_count unchanged. Assert rst during a held commit_req → no ack; all outputs 0.
- With BRANCH_RESOLVER_STATS_EN: 5 commits, 2 of them mispredicted → stat_commits = 5, stat_mispredicts = 2.
